// File: rtl/axis_arb_mux_if.sv
// AXI-Stream interface bundle shared by the arbiter inputs and output.
// Zero-width sideband parameters collapse to a single unused bit so the
// interface stays legal.
interface axis_if #(
  parameter int TDATA_WIDTH = 8,
  parameter int TID_WIDTH   = 0,
  parameter int TDEST_WIDTH = 0,
  parameter int TUSER_WIDTH = 0
);
  localparam int KW  = (TDATA_WIDTH + 7) / 8;
  localparam int IW  = (TID_WIDTH   > 0) ? TID_WIDTH   : 1;
  localparam int DSW = (TDEST_WIDTH > 0) ? TDEST_WIDTH : 1;
  localparam int UW  = (TUSER_WIDTH > 0) ? TUSER_WIDTH : 1;

  logic                   tvalid;
  logic                   tready;
  logic [TDATA_WIDTH-1:0] tdata;
  logic [KW-1:0]          tstrb;
  logic [KW-1:0]          tkeep;
  logic                   tlast;
  logic [IW-1:0]          tid;
  logic [DSW-1:0]         tdest;
  logic [UW-1:0]          tuser;
  logic                   twakeup;

  modport master (
    output tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser, twakeup,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser, twakeup,
    output tready
  );
endinterface

// File: rtl/axis_arb_mux.sv
// N-to-1 AXI-Stream packet arbiter with round-robin fairness.
// A grant is held from the arbitration cycle through the accepted tlast
// beat, so packets from different sources are never interleaved. One
// registered output stage gives full throughput once a packet is flowing.
// Optional feature: define AXIS_ARB_MUX_TID_EN to replace the outgoing tid
// with the source index of each beat (input tid is then ignored).
module axis_arb_mux #(
  parameter int NUM_INPUTS   = 4,
  parameter int TDATA_WIDTH  = 8,
  parameter int TID_WIDTH    = 0,
  parameter int TDEST_WIDTH  = 0,
  parameter int TUSER_WIDTH  = 0,
  parameter bit TKEEP_ENABLE = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  axis_if.slave                 s_axis [NUM_INPUTS],
  axis_if.master                m_axis,
  output logic [NUM_INPUTS-1:0] grant
);
  localparam int KW  = (TDATA_WIDTH + 7) / 8;
  localparam int IW  = (TID_WIDTH   > 0) ? TID_WIDTH   : 1;
  localparam int DSW = (TDEST_WIDTH > 0) ? TDEST_WIDTH : 1;
  localparam int UW  = (TUSER_WIDTH > 0) ? TUSER_WIDTH : 1;
  localparam int SW  = $clog2(NUM_INPUTS);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Elaboration-time parameter sanity.
  if (NUM_INPUTS < 2 || NUM_INPUTS > 16) begin : g_bad_num_inputs
    $error("axis_arb_mux: NUM_INPUTS must be within 2..16");
  end
`ifdef AXIS_ARB_MUX_TID_EN
  if (TID_WIDTH < SW) begin : g_bad_tid_width
    $error("axis_arb_mux: TID_WIDTH too narrow to carry the source index");
  end
`endif

  // Flattened copies of the input streams so they can be indexed at run time.
  logic [NUM_INPUTS-1:0]  in_valid;
  logic [NUM_INPUTS-1:0]  in_ready;
  logic [NUM_INPUTS-1:0]  in_last;
  logic [TDATA_WIDTH-1:0] in_data [NUM_INPUTS];
  logic [KW-1:0]          in_strb [NUM_INPUTS];
  logic [KW-1:0]          in_keep [NUM_INPUTS];
  logic [IW-1:0]          in_id   [NUM_INPUTS];
  logic [DSW-1:0]         in_dest [NUM_INPUTS];
  logic [UW-1:0]          in_user [NUM_INPUTS];
  logic [NUM_INPUTS-1:0]  unused_in;

  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_unpack
    assign in_valid[i]       = s_axis[i].tvalid;
    assign in_last[i]        = s_axis[i].tlast;
    assign in_data[i]        = s_axis[i].tdata;
    assign in_strb[i]        = s_axis[i].tstrb;
    assign in_keep[i]        = s_axis[i].tkeep;
    assign in_id[i]          = s_axis[i].tid;
    assign in_dest[i]        = s_axis[i].tdest;
    assign in_user[i]        = s_axis[i].tuser;
    assign s_axis[i].tready  = in_ready[i];
    // twakeup is not forwarded; tid is dropped when the source index replaces it.
    assign unused_in[i]      = s_axis[i].twakeup ^ (^s_axis[i].tid);
  end

  // Control state.
  state_t          state;
  logic [SW-1:0]   last_ptr;
  logic [SW-1:0]   own_idx;

  // Output register stage (p1).
  logic                   out_valid_p1;
  logic [TDATA_WIDTH-1:0] out_data_p1;
  logic [KW-1:0]          out_strb_p1;
  logic [KW-1:0]          out_keep_p1;
  logic                   out_last_p1;
  logic [IW-1:0]          out_id_p1;
  logic [DSW-1:0]         out_dest_p1;
  logic [UW-1:0]          out_user_p1;

  // Arbitration and selection signals.
  logic                  pick_found;
  logic [SW-1:0]         pick_idx;
  logic [SW-1:0]         cand;
  logic [NUM_INPUTS-1:0] pick_onehot;
  logic                  stall_free;
  logic                  accept;
  logic                  sel_last;
  logic [IW-1:0]         sel_id;

  // Round-robin search: first valid requester after the previous winner.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 1; k <= NUM_INPUTS; k++) begin
      cand = SW'((int'(last_ptr) + k) % NUM_INPUTS);
      if (!pick_found && in_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign pick_onehot = NUM_INPUTS'(1) << pick_idx;

  // The output register can take a new beat when empty or draining this cycle.
  assign stall_free = !out_valid_p1 || m_axis.tready;
  assign in_ready   = (state == BUSY) ? (grant & {NUM_INPUTS{stall_free}}) : '0;
  assign accept     = |(in_valid & in_ready);
  assign sel_last   = in_last[own_idx];

`ifdef AXIS_ARB_MUX_TID_EN
  assign sel_id = IW'(own_idx);
`else
  assign sel_id = in_id[own_idx];
`endif

  // Arbiter FSM plus output register; grant and pointer move together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      grant        <= '0;
      last_ptr     <= SW'(NUM_INPUTS - 1);
      own_idx      <= '0;
      out_valid_p1 <= 1'b0;
      out_data_p1  <= '0;
      out_strb_p1  <= '0;
      out_keep_p1  <= '0;
      out_last_p1  <= 1'b0;
      out_id_p1    <= '0;
      out_dest_p1  <= '0;
      out_user_p1  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            state    <= BUSY;
            grant    <= pick_onehot;
            last_ptr <= pick_idx;
            own_idx  <= pick_idx;
          end
        end
        BUSY: begin
          if (accept && sel_last) begin
            state <= IDLE;
            grant <= '0;
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
        end
      endcase

      // ---- output stage p1 ----
      if (accept) begin
        out_valid_p1 <= 1'b1;
        out_data_p1  <= in_data[own_idx];
        out_strb_p1  <= in_strb[own_idx];
        out_keep_p1  <= in_keep[own_idx];
        out_last_p1  <= sel_last;
        out_id_p1    <= sel_id;
        out_dest_p1  <= in_dest[own_idx];
        out_user_p1  <= in_user[own_idx];
      end else if (m_axis.tready) begin
        out_valid_p1 <= 1'b0;
      end
    end
  end

  assign m_axis.tvalid  = out_valid_p1;
  assign m_axis.tdata   = out_data_p1;
  assign m_axis.tstrb   = out_strb_p1;
  assign m_axis.tkeep   = TKEEP_ENABLE ? out_keep_p1 : '1;
  assign m_axis.tlast   = out_last_p1;
  assign m_axis.tid     = out_id_p1;
  assign m_axis.tdest   = out_dest_p1;
  assign m_axis.tuser   = out_user_p1;
  assign m_axis.twakeup = 1'b0;
endmodule
